// File: rtl/video_pkg.sv
// Shared types for the video pattern generator: pattern mode encoding and
// the colour-bar on/off table.
package video_pkg;

    // Run-time selectable output pattern.
    typedef enum logic [1:0] {
        PAT_DIAG  = 2'd0,
        PAT_GRID  = 2'd1,
        PAT_BARS  = 2'd2,
        PAT_SOLID = 2'd3
    } pattern_mode_t;

    // Per-bar {R,G,B} on/off mask, left to right:
    // white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        m = 3'b000;
        case (idx)
            3'd0: m = 3'b111;
            3'd1: m = 3'b110;
            3'd2: m = 3'b011;
            3'd3: m = 3'b010;
            3'd4: m = 3'b101;
            3'd5: m = 3'b100;
            3'd6: m = 3'b001;
            3'd7: m = 3'b000;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/video_timing_core.sv
// Free-running horizontal/vertical counters and the raw (unregistered) timing
// flags derived from them.
// Ports:
//   clk_i, rst_ni      pixel clock, async active-low reset
//   hsync_c_o          hcounter < HSYNC
//   vsync_c_o          vcounter < VSYNC
//   de_c_o             counters inside the active area
//   x_c_o, y_c_o       active coordinates (valid while de_c_o)
//   frame_start_c_o    counters at (0,0)
//   line_end_c_o       hcounter at HTOTAL-1
//   x_pre_c_o          hcounter one pixel before x==0
//   y_pre_c_o          vcounter on the line before y==0
//   y_act_c_o          vcounter inside the active rows
module video_timing_core #(
    parameter int unsigned HSYNC   = 40,
    parameter int unsigned HBACK   = 220,
    parameter int unsigned HACTIVE = 1280,
    parameter int unsigned HFRONT  = 110,
    parameter int unsigned VSYNC   = 5,
    parameter int unsigned VBACK   = 20,
    parameter int unsigned VACTIVE = 720,
    parameter int unsigned VFRONT  = 5,
    parameter int unsigned HW      = $clog2(HSYNC + HBACK + HACTIVE + HFRONT),
    parameter int unsigned VW      = $clog2(VSYNC + VBACK + VACTIVE + VFRONT)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    output logic          hsync_c_o,
    output logic          vsync_c_o,
    output logic          de_c_o,
    output logic [HW-1:0] x_c_o,
    output logic [VW-1:0] y_c_o,
    output logic          frame_start_c_o,
    output logic          line_end_c_o,
    output logic          x_pre_c_o,
    output logic          y_pre_c_o,
    output logic          y_act_c_o
);

    localparam int unsigned HTOTAL = HSYNC + HBACK + HACTIVE + HFRONT;
    localparam int unsigned VTOTAL = VSYNC + VBACK + VACTIVE + VFRONT;
    localparam int unsigned HOFF   = HSYNC + HBACK;
    localparam int unsigned VOFF   = VSYNC + VBACK;
    localparam int unsigned HW1    = HW + 1;
    localparam int unsigned VW1    = VW + 1;

    logic [HW-1:0] hcount_q, hcount_d;
    logic [VW-1:0] vcount_q, vcount_d;
    logic          h_wrap_c, v_wrap_c, h_act_c;

    assign h_wrap_c = (hcount_q == HW'(HTOTAL - 1));
    assign v_wrap_c = (vcount_q == VW'(VTOTAL - 1));

    // Counter next-state: h wraps every line, v steps on h wrap.
    always_comb begin
        hcount_d = h_wrap_c ? '0 : hcount_q + HW'(1);
        vcount_d = vcount_q;
        if (h_wrap_c) begin
            vcount_d = v_wrap_c ? '0 : vcount_q + VW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcount_q <= '0;
            vcount_q <= '0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
        end
    end

    // Active-window compares are one bit wider so HFRONT/VFRONT of 0 cannot overflow.
    assign h_act_c   = ({1'b0, hcount_q} >= HW1'(HOFF)) && ({1'b0, hcount_q} < HW1'(HOFF + HACTIVE));
    assign y_act_c_o = ({1'b0, vcount_q} >= VW1'(VOFF)) && ({1'b0, vcount_q} < VW1'(VOFF + VACTIVE));

    assign hsync_c_o       = (hcount_q < HW'(HSYNC));
    assign vsync_c_o       = (vcount_q < VW'(VSYNC));
    assign de_c_o          = h_act_c && y_act_c_o;
    assign x_c_o           = hcount_q - HW'(HOFF);
    assign y_c_o           = vcount_q - VW'(VOFF);
    assign frame_start_c_o = (hcount_q == '0) && (vcount_q == '0);
    assign line_end_c_o    = h_wrap_c;
    assign x_pre_c_o       = (hcount_q == HW'(HOFF - 1));
    assign y_pre_c_o       = (vcount_q == VW'(VOFF - 1));

endmodule

// File: rtl/video_pattern_generator.sv
// Video timing plus run-time selectable test pattern (diagonal, grid, colour
// bars, solid). Pattern and colours are shadowed at frame start so frames
// never tear. All outputs registered, one cycle after the counter state.
// Optional feature: DIAGRAM_SCROLL_EN adds a per-frame scroll offset to the
// diagonal and grid columns.
// Ports:
//   clock, reset_n     pixel clock, async active-low reset
//   mode               pattern select (video_pkg::pattern_mode_t), frame-sampled
//   fg_color, bg_color {R,G,B} colours, frame-sampled
//   video_data         pixel {R,G,B}, 0 outside the active area
//   video_de           active-area strobe
//   video_hsync/vsync  positive-polarity syncs
//   frame_start        one-cycle pulse at counter position (0,0)
module video_pattern_generator
    import video_pkg::*;
#(
    parameter int unsigned HSYNC      = 40,
    parameter int unsigned HBACK      = 220,
    parameter int unsigned HACTIVE    = 1280,
    parameter int unsigned HFRONT     = 110,
    parameter int unsigned VSYNC      = 5,
    parameter int unsigned VBACK      = 20,
    parameter int unsigned VACTIVE    = 720,
    parameter int unsigned VFRONT     = 5,
    parameter int unsigned COLOR_BITS = 8,
    parameter int unsigned GRID       = 64
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [1:0]                mode,
    input  logic [3*COLOR_BITS-1:0]   fg_color,
    input  logic [3*COLOR_BITS-1:0]   bg_color,
    output logic [3*COLOR_BITS-1:0]   video_data,
    output logic                      video_de,
    output logic                      video_hsync,
    output logic                      video_vsync,
    output logic                      frame_start
);

    localparam int unsigned PW     = 3 * COLOR_BITS;
    localparam int unsigned HTOTAL = HSYNC + HBACK + HACTIVE + HFRONT;
    localparam int unsigned VTOTAL = VSYNC + VBACK + VACTIVE + VFRONT;
    localparam int unsigned HW     = $clog2(HTOTAL);
    localparam int unsigned VW     = $clog2(VTOTAL);
    localparam int unsigned SW     = $clog2(GRID);
    localparam int unsigned DW     = ((HW > VW) ? HW : VW) + 1;
    localparam int unsigned BAR_W  = HACTIVE / 8;
    localparam int unsigned SEGW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic          hsync_c, vsync_c, de_c, frame_start_c;
    logic          line_end_c, x_pre_c, y_pre_c, y_act_c;
    logic [HW-1:0] x_c;
    logic [VW-1:0] y_c;

    video_timing_core #(
        .HSYNC   (HSYNC),
        .HBACK   (HBACK),
        .HACTIVE (HACTIVE),
        .HFRONT  (HFRONT),
        .VSYNC   (VSYNC),
        .VBACK   (VBACK),
        .VACTIVE (VACTIVE),
        .VFRONT  (VFRONT),
        .HW      (HW),
        .VW      (VW)
    ) u_timing (
        .clk_i           (clock),
        .rst_ni          (reset_n),
        .hsync_c_o       (hsync_c),
        .vsync_c_o       (vsync_c),
        .de_c_o          (de_c),
        .x_c_o           (x_c),
        .y_c_o           (y_c),
        .frame_start_c_o (frame_start_c),
        .line_end_c_o    (line_end_c),
        .x_pre_c_o       (x_pre_c),
        .y_pre_c_o       (y_pre_c),
        .y_act_c_o       (y_act_c)
    );

    // Frame-start shadows of the control inputs.
    pattern_mode_t mode_sh_q;
    logic [PW-1:0] fg_sh_q, bg_sh_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_sh_q <= PAT_DIAG;
            fg_sh_q   <= '1;
            bg_sh_q   <= '0;
        end else if (frame_start_c) begin
            mode_sh_q <= pattern_mode_t'(mode);
            fg_sh_q   <= fg_color;
            bg_sh_q   <= bg_color;
        end
    end

    // Scroll offset: scroll_q counts frames, scroll_sh is the value frozen for the current frame.
    logic [SW-1:0] scroll_sh;
`ifdef DIAGRAM_SCROLL_EN
    logic [SW-1:0] scroll_q, scroll_d, scroll_sh_q;

    always_comb begin
        scroll_d = (scroll_q == SW'(GRID - 1)) ? '0 : scroll_q + SW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            scroll_q    <= '0;
            scroll_sh_q <= '0;
        end else if (frame_start_c) begin
            scroll_sh_q <= scroll_q;
            scroll_q    <= scroll_d;
        end
    end

    assign scroll_sh = scroll_sh_q;
`else
    assign scroll_sh = '0;
`endif

    // Pattern counters track the pixel currently on the counters:
    // gx = (x+s)%GRID, gy = y%GRID, seg/bar = position within the colour bars.
    logic [SW-1:0]   gx_q, gx_d, gy_q, gy_d;
    logic [SEGW-1:0] seg_q, seg_d;
    logic [2:0]      bar_q, bar_d;

    always_comb begin
        gx_d  = gx_q;
        gy_d  = gy_q;
        seg_d = seg_q;
        bar_d = bar_q;
        // Preloaded one pixel early so the value is ready at x==0.
        if (x_pre_c) begin
            gx_d  = scroll_sh;
            seg_d = '0;
            bar_d = '0;
        end else if (de_c) begin
            gx_d = (gx_q == SW'(GRID - 1)) ? '0 : gx_q + SW'(1);
            if (seg_q == SEGW'(BAR_W - 1)) begin
                seg_d = '0;
                bar_d = bar_q + 3'd1;
            end else begin
                seg_d = seg_q + SEGW'(1);
            end
        end
        if (line_end_c) begin
            if (y_pre_c) begin
                gy_d = '0;
            end else if (y_act_c) begin
                gy_d = (gy_q == SW'(GRID - 1)) ? '0 : gy_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gx_q  <= '0;
            gy_q  <= '0;
            seg_q <= '0;
            bar_q <= '0;
        end else begin
            gx_q  <= gx_d;
            gy_q  <= gy_d;
            seg_q <= seg_d;
            bar_q <= bar_d;
        end
    end

    // Pixel selection for the current counter position.
    logic [PW-1:0] pix_c;
    logic [2:0]    mask_c;

    always_comb begin
        pix_c  = bg_sh_q;
        mask_c = bar_mask(bar_q);
        case (mode_sh_q)
            PAT_DIAG:  if (DW'(x_c) == DW'(y_c) + DW'(scroll_sh)) pix_c = fg_sh_q;
            PAT_GRID:  if ((gx_q == '0) || (gy_q == '0)) pix_c = fg_sh_q;
            PAT_BARS:  pix_c = {{COLOR_BITS{mask_c[2]}}, {COLOR_BITS{mask_c[1]}}, {COLOR_BITS{mask_c[0]}}};
            PAT_SOLID: pix_c = fg_sh_q;
            default:   pix_c = bg_sh_q;
        endcase
    end

    // Output register stage; keeps sync, DE, data and frame_start aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            video_data  <= '0;
            video_de    <= 1'b0;
            video_hsync <= 1'b0;
            video_vsync <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_data  <= de_c ? pix_c : '0;
            video_de    <= de_c;
            video_hsync <= hsync_c;
            video_vsync <= vsync_c;
            frame_start <= frame_start_c;
        end
    end

endmodule
